// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store sequencer between the execute stage and DataMemory.
//            Accepts one byte/halfword/word access per request, holds the
//            memory strobes for WAIT_CYCLES cycles while stalling the
//            pipeline with busy, then returns lane-extracted, sign- or
//            zero-extended load data with a one-cycle rsp_valid pulse.
// Ports    : clk, Reset (async, active-low)
//            req, req_we, req_size, req_unsigned, req_addr, req_wdata  - request
//            busy, rsp_valid, rsp_rdata, misaligned                    - response
//            MemoryAddress, memRD, memWD, DataIn, byte_en, DataOut     - memory
// Params   : WAIT_CYCLES (1..15) strobe hold time per access
// Macro    : MISALIGN_TRAP_EN - when defined, misaligned requests skip the
//            memory access and complete with misaligned=1; when undefined,
//            the offending low address bits are cleared and the access runs.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misaligned,
    output logic [31:0] MemoryAddress,
    output logic        memRD,
    output logic        memWD,
    output logic [31:0] DataIn,
    output logic [3:0]  byte_en,
    input  logic [31:0] DataOut
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ACCESS   = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;
    localparam logic [3:0] c_CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_inAccess;
    logic        w_isHalf;
    logic        w_isWord;
    logic [31:0] w_reqAddr;
    logic [7:0]  w_loadByte;
    logic [15:0] w_loadHalf;
    logic [31:0] w_loadData;

    // A new request can be taken whenever the pipeline is not stalled,
    // which includes the DONE cycle (back-to-back accept).
    assign w_accept   = req && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_inAccess = (r_state == c_ACCESS);
    assign w_isHalf   = (req_size == 2'b01);
    assign w_isWord   = req_size[1];          // 10 and 11 are both word

`ifdef MISALIGN_TRAP_EN
    logic w_reqMis;
    logic r_misaligned;

    assign w_reqMis  = (w_isHalf && req_addr[0]) || (w_isWord && (req_addr[1:0] != 2'b00));
    assign w_reqAddr = req_addr;
    assign misaligned = (r_state == c_DONE) && r_misaligned;
`else
    // Silently align: drop addr[0] for halfwords, addr[1:0] for words.
    assign w_reqAddr = {req_addr[31:2],
                        req_addr[1] & ~w_isWord,
                        req_addr[0] & ~(w_isHalf | w_isWord)};
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= c_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 32'd0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
        end else if (w_accept) begin
            r_addr     <= w_reqAddr;
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            r_cnt      <= c_CNT_INIT;
`ifdef MISALIGN_TRAP_EN
            r_misaligned <= w_reqMis;
            r_state      <= w_reqMis ? c_DONE : c_ACCESS;
`else
            r_state    <= c_ACCESS;
`endif
        end else begin
            case (r_state)
                c_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_DONE;
                        // Capture on the last strobe edge so rsp_rdata is
                        // stable for the whole rsp_valid cycle.
                        if (!r_we) begin
                            r_rdata <= w_loadData;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                c_IDLE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Load lane extraction from the (already aligned) latched address.
    always_comb begin
        w_loadByte = DataOut[7:0];
        case (r_addr[1:0])
            2'd0:    w_loadByte = DataOut[7:0];
            2'd1:    w_loadByte = DataOut[15:8];
            2'd2:    w_loadByte = DataOut[23:16];
            default: w_loadByte = DataOut[31:24];
        endcase
    end

    assign w_loadHalf = r_addr[1] ? DataOut[31:16] : DataOut[15:0];

    always_comb begin
        w_loadData = DataOut;
        case (r_size)
            2'b00:   w_loadData = {{24{~r_unsigned & w_loadByte[7]}}, w_loadByte};
            2'b01:   w_loadData = {{16{~r_unsigned & w_loadHalf[15]}}, w_loadHalf};
            default: w_loadData = DataOut;
        endcase
    end

    // Store lane placement; everything is zero outside ACCESS.
    always_comb begin
        byte_en = 4'b0000;
        DataIn  = 32'd0;
        if (w_inAccess) begin
            case (r_size)
                2'b00: begin
                    byte_en = 4'b0001 << r_addr[1:0];
                    DataIn  = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    byte_en = 4'b0011 << {r_addr[1], 1'b0};
                    DataIn  = {2{r_wdata[15:0]}};
                end
                default: begin
                    byte_en = 4'b1111;
                    DataIn  = r_wdata;
                end
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign busy          = w_inAccess;
    assign rsp_valid     = (r_state == c_DONE);
    assign rsp_rdata     = r_rdata;
    assign memRD         = w_inAccess && !r_we;
    assign memWD         = w_inAccess && r_we;
    assign MemoryAddress = w_inAccess ? {r_addr[31:2], 2'b00} : 32'd0;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the execute stage and `DataMemory`. It accepts one byte, halfword or word access per request and drives the memory's address, read/write strobes and write data. It holds the pipeline with `busy` for a programmable number of wait cycles. It returns lane-extracted, sign- or zero-extended load data with a one-cycle `rsp_valid` pulse.

## Interface
- `WAIT_CYCLES`, 1: cycles that `memRD`/`memWD` are held per access; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request from execute stage; sampled only when `busy`=0.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- `req_unsigned`  in  1  1 = zero-extend loads, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `busy`  out  1  stall to pipeline.
- `rsp_valid`  out  1  one-cycle completion pulse, for loads and stores.
- `rsp_rdata`  out  32  extended load data; holds its value between loads.
- `misaligned`  out  1  fault flag, valid with `rsp_valid`.
- `MemoryAddress`  out  32  word-aligned address to `DataMemory`.
- `memRD`  out  1  read strobe.
- `memWD`  out  1  write strobe.
- `DataIn`  out  32  store data placed in its byte lane(s).
- `byte_en`  out  4  lane enables; bit i = bits [8i+7:8i].
- `DataOut`  in  32  read data from `DataMemory`.

## Operation
- States and transitions:
  - IDLE → ACCESS on `req`. The accept edge latches addr, we, size, unsigned and wdata, and loads the wait counter with `WAIT_CYCLES`-1.
  - ACCESS: `memRD`=!we, `memWD`=we. The counter decrements each cycle. At counter = 0 the state moves to DONE, and a load captures `DataOut` on that edge.
  - DONE: `rsp_valid`=1, strobes 0, `busy`=0. Goes to ACCESS if `req` is present (back-to-back accept), else to IDLE.
- `busy`=1 in ACCESS. `busy`=0 in IDLE and DONE.
- `MemoryAddress` = {addr[31:2], 2'b00} while in ACCESS, otherwise 0.
- `byte_en` and `DataIn`:
  - byte: 4'b0001 << addr[1:0], with wdata[7:0] replicated to all four lanes.
  - half: 4'b0011 << {addr[1],1'b0}, with wdata[15:0] replicated to both halves.
  - word: 4'b1111, with `DataIn` = wdata.
  - `byte_en` and `DataIn` are 0 outside ACCESS.
- Load extraction:
  - The byte lane is selected by addr[1:0]; the halfword is selected by addr[1].
  - Bit 7 or bit 15 is extended unless `req_unsigned`=1.
  - Word loads pass through unchanged.
- Stores complete with `rsp_valid` and leave `rsp_rdata` unchanged.
- Misalignment conditions are a halfword with addr[0]=1, or a word with addr[1:0]≠0. Handling is set by the macro in Configuration.

## Timing
- Request accepted at edge E0. Strobes are high for cycles E0..E0+`WAIT_CYCLES`-1. `rsp_valid` is high for the cycle following edge E0+`WAIT_CYCLES`.
- Latency from `req` to `rsp_valid` is `WAIT_CYCLES`+1 cycles. Throughput is one access per `WAIT_CYCLES`+1 cycles, including back-to-back.
- Load data is registered, so `rsp_rdata` is stable throughout the `rsp_valid` cycle.
- `req` changes while `busy`=1 are ignored; the latched request is used.
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset asserted mid-access: strobes drop immediately and asynchronously, and no `rsp_valid` is issued for the aborted access.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A misaligned request goes from IDLE directly to DONE; the ACCESS state is skipped.
  - No strobes are issued and memory is not touched.
  - `rsp_valid`=1 and `misaligned`=1 one cycle after accept. `rsp_rdata` is unchanged.
- `MISALIGN_TRAP_EN` undefined:
  - Offending low address bits are cleared: addr[0] for halfwords, addr[1:0] for words.
  - The access proceeds normally.
  - `misaligned` is tied to 0.

## Test plan
- Reset: hold `Reset`=0 with `req`=1 → all outputs 0. Release → the first `req` is accepted on the next edge.
- Signed byte load, `WAIT_CYCLES`=2:
  - Stimulus: addr 0x103, size 00, `DataOut`=0x80AABBCC.
  - `memRD` high 2 cycles, `MemoryAddress`=0x100, `byte_en`=1000.
  - `rsp_rdata`=0xFFFFFF80 with `rsp_valid` in cycle 3.
  - The same access with `req_unsigned`=1 → 0x00000080.
- Halfword store:
  - Stimulus: addr 0x22, wdata 0x1234ABCD.
  - `memWD`=1, `byte_en`=1100, `DataIn`=0xABCDABCD, `rsp_rdata` unchanged.
- Back-to-back: hold `req` high across two word loads → second accept occurs in the DONE cycle, with no idle cycle between strobe windows.
- Reset mid-access: assert `Reset` during ACCESS → `memRD` low at once, and no `rsp_valid` follows.
- Misaligned word load at addr 0x101:
  - With `MISALIGN_TRAP_EN`: `misaligned`=1 with `rsp_valid` one cycle later and no strobe.
  - Without: access to 0x100 with `byte_en`=1111.
